serial_addsub: RTL



---
 rtl/serial_addsub_if.sv | 24 ++
 rtl/serial_addsub.sv | 93 +++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry,
// LSB first, WIDTH cycles per operation, start/busy/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             cnx;
    logic             last;

    always_comb begin
        s    = areg[0] ^ breg[0] ^ carry;
        cnx  = ((areg[0] ^ breg[0]) & carry) | (areg[0] & breg[0]);
        last = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN:  if (last)      state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    // Subtraction is a + ~b + 1: invert B at capture and seed the carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg     <= '0;
            breg     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        areg  <= bus.a;
                        breg  <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    res   <= {s, res[WIDTH-1:1]};
                    carry <= cnx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        bus.sum  <= {s, res[WIDTH-1:1]};
                        bus.cout <= cnx;
                        // carry still holds the carry into the MSB here
                        bus.ovf  <= carry ^ cnx;
                        bus.done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
